// File: rtl/bitfusion_pkg.sv
// rtl/bitfusion_pkg.sv - shared types and default sizes for the BitFusion output drain
package bitfusion_pkg;

    localparam int ARRAY_SIZE_D = 4;
    localparam int DATA_W_D     = 32;
    localparam int OUT_W_D      = 16;
    localparam int ADDR_W_D     = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/obuf_drain_psum_quant.sv
// rtl/obuf_drain_psum_quant.sv - combinational round/shift/ReLU/saturate of one partial sum
module psum_quant #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 16
) (
    input  logic [DATA_W-1:0] i_s,
    input  logic [4:0]        i_shift,
    input  logic              i_relu_en,
    output logic [OUT_W-1:0]  o_data
);

    // One extra bit of headroom so adding the rounding constant cannot wrap.
    localparam logic signed [DATA_W:0] W_MAX = $signed({{(DATA_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [DATA_W:0] W_MIN = $signed({{(DATA_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});

    logic signed [DATA_W:0] w_ext;
    logic signed [DATA_W:0] w_half;
    logic signed [DATA_W:0] w_rnd;
    logic signed [DATA_W:0] w_relu;
    logic signed [DATA_W:0] w_sat;

    // Round half up, arithmetic shift, optional ReLU, then clamp to the output range.
    always_comb begin
        w_ext  = $signed({i_s[DATA_W-1], i_s});
        w_half = '0;
        w_rnd  = w_ext;
        if (i_shift != 5'd0) begin
            w_half = $signed({{DATA_W{1'b0}}, 1'b1} << (i_shift - 5'd1));
            w_rnd  = (w_ext + w_half) >>> i_shift;
        end
        w_relu = (i_relu_en && (w_rnd < 0)) ? '0 : w_rnd;
        if (w_relu > W_MAX) begin
            w_sat = W_MAX;
        end else if (w_relu < W_MIN) begin
            w_sat = W_MIN;
        end else begin
            w_sat = w_relu;
        end
        o_data = w_sat[OUT_W-1:0];
    end

endmodule

// File: rtl/obuf_drain.sv
// rtl/obuf_drain.sv - snapshot accumulator columns and drain them, quantized, to the output SRAM
module obuf_drain
    import bitfusion_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_D,
    parameter int DATA_W     = DATA_W_D,
    parameter int OUT_W      = OUT_W_D,
    parameter int ADDR_W     = ADDR_W_D
) (
    input  logic                             clk,
    input  logic                             nRST,
    input  logic                             start,
    input  logic [ARRAY_SIZE-1:0][DATA_W-1:0] acc_sums,
    input  logic [4:0]                       shift,
    input  logic                             relu_en,
    input  logic [ADDR_W-1:0]                base_addr,
    output logic [ARRAY_SIZE-1:0]            acc_clear,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_W-1:0]                 out_data,
    output logic [ADDR_W-1:0]                out_addr,
    output logic                             busy,
    output logic                             done,
    output logic                             overrun
);

    localparam int COL_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ARRAY_SIZE - 1);

    drain_state_t                      r_state;
    drain_state_t                      w_next;
    logic [COL_W-1:0]                  r_col;
    logic [ARRAY_SIZE-1:0][DATA_W-1:0] r_snap;
    logic [4:0]                        r_shift;
    logic                              r_relu;
    logic [ADDR_W-1:0]                 r_base;
    logic                              r_clear;
    logic                              r_overrun;
    logic                              w_take;
    logic                              w_fire;
    logic                              w_last;

    assign w_take = (r_state == IDLE) && start;
    assign w_fire = out_valid && out_ready;
    assign w_last = (r_col == LAST_COL);

    // State register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: one pass over the columns, then a single DONE cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = DRAIN;
            DRAIN:   if (w_fire && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Snapshot, latched controls, column counter, clear pulse and sticky overrun.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_col     <= '0;
            r_snap    <= '0;
            r_shift   <= '0;
            r_relu    <= 1'b0;
            r_base    <= '0;
            r_clear   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_clear <= w_take;
            if (start && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_take) begin
                r_snap  <= acc_sums;
                r_shift <= shift;
                r_relu  <= relu_en;
                r_base  <= base_addr;
                r_col   <= '0;
            end else if (w_fire && !w_last) begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Single quantizer shared across columns; it only ever sees registered state,
    // so the word is stable for as long as the consumer stalls.
    psum_quant #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_quant (
        .i_s       (r_snap[r_col]),
        .i_shift   (r_shift),
        .i_relu_en (r_relu),
        .o_data    (out_data)
    );

    assign out_addr  = r_base + ADDR_W'(r_col);
    assign out_valid = (r_state == DRAIN);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign acc_clear = {ARRAY_SIZE{r_clear}};
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_obuf_drain.sv
// tb/tb_obuf_drain.sv - scoreboard testbench for obuf_drain
module tb_obuf_drain;

    logic              clk = 1'b0;
    logic              nRST = 1'b0;
    logic              start = 1'b0;
    logic [3:0][31:0]  acc_sums = '0;
    logic [4:0]        shift = '0;
    logic              relu_en = 1'b0;
    logic [9:0]        base_addr = '0;
    logic [3:0]        acc_clear;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [15:0]       out_data;
    logic [9:0]        out_addr;
    logic              busy;
    logic              done;
    logic              overrun;

    typedef struct packed {
        logic [15:0] d;
        logic [9:0]  a;
    } word_t;

    word_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    obuf_drain dut (
        .clk       (clk),
        .nRST      (nRST),
        .start     (start),
        .acc_sums  (acc_sums),
        .shift     (shift),
        .relu_en   (relu_en),
        .base_addr (base_addr),
        .acc_clear (acc_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][31:0] mk(input int a, input int b, input int c, input int d);
        logic [3:0][31:0] r;
        r[0] = 32'(a);
        r[1] = 32'(b);
        r[2] = 32'(c);
        r[3] = 32'(d);
        return r;
    endfunction

    // Monitor: every accepted word must be the next one the stimulus expected.
    always @(negedge clk) begin
        word_t w;
        if (nRST && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_word: got data %0h addr %0h, expected no word", out_data, out_addr);
            end else begin
                w = exp_q.pop_front();
                chk("word_data", {16'h0, out_data}, {16'h0, w.d});
                chk("word_addr", {22'h0, out_addr}, {22'h0, w.a});
            end
        end
    end

    task automatic push_words(input logic [9:0] base, input int e0, input int e1,
                              input int e2, input int e3, input int n);
        int e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({16'(e[k]), 10'(base + 10'(k))});
        end
    endtask

    task automatic run_tile(input logic [3:0][31:0] sums, input logic [4:0] sh, input logic rl,
                            input logic [9:0] base, input int e0, input int e1, input int e2,
                            input int e3, input int stall_at, input int stall_n, input int ovr_k,
                            input int exp_len);
        int          k;
        logic [15:0] hold_d;
        logic [9:0]  hold_a;
        logic        stall;
        push_words(base, e0, e1, e2, e3, 4);
        acc_sums  = sums;
        shift     = sh;
        relu_en   = rl;
        base_addr = base;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        acc_sums = ~sums;
        hold_d   = '0;
        hold_a   = '0;
        k = 1;
        while (k < 60) begin
            chk("acc_clear", {28'h0, acc_clear}, (k == 1) ? 32'hF : 32'h0);
            if (done) break;
            chk("out_valid_drain", {31'h0, out_valid}, 32'h1);
            stall = (stall_n > 0) && (k >= stall_at) && (k < stall_at + stall_n);
            out_ready = !stall;
            if (stall_n > 0 && k == stall_at) begin
                hold_d = out_data;
                hold_a = out_addr;
            end else if (stall_n > 0 && k > stall_at && k <= stall_at + stall_n) begin
                chk("stall_data_hold", {16'h0, out_data}, {16'h0, hold_d});
                chk("stall_addr_hold", {22'h0, out_addr}, {22'h0, hold_a});
            end
            start = (k == ovr_k);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        chk("done_cycle", 32'(k), 32'(exp_len));
        chk("valid_in_done", {31'h0, out_valid}, 32'h0);
        chk("busy_in_done", {31'h0, busy}, 32'h1);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_pulse_width", {31'h0, done}, 32'h0);
        chk("idle_not_busy", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",   {31'h0, out_valid}, 32'h0);
        chk("rst_busy",    {31'h0, busy},      32'h0);
        chk("rst_done",    {31'h0, done},      32'h0);
        chk("rst_overrun", {31'h0, overrun},   32'h0);
        chk("rst_clear",   {28'h0, acc_clear}, 32'h0);
        chk("rst_data",    {16'h0, out_data},  32'h0);
        chk("rst_addr",    {22'h0, out_addr},  32'h0);
        nRST = 1'b1;
        @(posedge clk); #1;

        // Basic: positive saturation at column 3.
        run_tile(mk(100, -7, 0, 65535), 5'd0, 1'b0, 10'h010, 100, -7, 0, 32767, 0, 0, 0, 5);
        chk("overrun_clean", {31'h0, overrun}, 32'h0);

        // Rounding with and without ReLU.
        run_tile(mk(5, 6, -6, -5), 5'd2, 1'b1, 10'h040, 1, 2, 0, 0, 0, 0, 0, 5);
        run_tile(mk(5, 6, -6, -5), 5'd2, 1'b0, 10'h040, 1, 2, -1, -1, 0, 0, 0, 5);

        // Backpressure on column 1 for three cycles.
        run_tile(mk(1000, 2000, 3000, 4000), 5'd0, 1'b0, 10'h020, 1000, 2000, 3000, 4000, 2, 3, 0, 8);

        // Address wrap, shift of 31 at the rounding extremes, and a start during DRAIN.
        run_tile(mk(32'h7FFFFFFF, 32'h80000000, 3, -3), 5'd31, 1'b0, 10'h3FE, 1, -1, 0, 0, 0, 0, 2, 5);
        chk("overrun_set", {31'h0, overrun}, 32'h1);

        // Back-to-back tiles, second one saturating in both directions.
        run_tile(mk(10, 20, 30, 40), 5'd0, 1'b0, 10'h000, 10, 20, 30, 40, 0, 0, 0, 5);
        run_tile(mk(-40000, 32767, -32768, 32768), 5'd0, 1'b0, 10'h004, -32768, 32767, -32768, 32767, 0, 0, 0, 5);
        chk("overrun_sticky", {31'h0, overrun}, 32'h1);

        // Reset in the middle of a drain, right after column 1 is accepted.
        push_words(10'h100, 11, 22, 0, 0, 2);
        acc_sums  = mk(11, 22, 33, 44);
        shift     = 5'd0;
        relu_en   = 1'b0;
        base_addr = 10'h100;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nRST = 1'b0;
        #1;
        chk("mid_rst_valid",   {31'h0, out_valid}, 32'h0);
        chk("mid_rst_busy",    {31'h0, busy},      32'h0);
        chk("mid_rst_done",    {31'h0, done},      32'h0);
        chk("mid_rst_overrun", {31'h0, overrun},   32'h0);
        chk("mid_rst_clear",   {28'h0, acc_clear}, 32'h0);
        chk("mid_rst_data",    {16'h0, out_data},  32'h0);
        chk("mid_rst_addr",    {22'h0, out_addr},  32'h0);
        chk("mid_rst_words",   32'(exp_q.size()),  32'h0);
        @(posedge clk); #1;
        nRST = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {31'h0, out_valid}, 32'h0);
        run_tile(mk(-1, 300, 70000, -70000), 5'd1, 1'b0, 10'h200, 0, 150, 32767, -32768, 0, 0, 0, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
